// File: rtl/iob_cache_req_arbiter_pkg.sv
// Shared types and helpers for the cache request arbiter: state encoding,
// owner-id width derivation and bus slice indexing.
package iob_cache_req_arbiter_pkg;

   typedef enum logic {
      ST_IDLE    = 1'b0,
      ST_RD_WAIT = 1'b1
   } arb_state_t;

   // Owner-id width; a single bit is kept even for degenerate counts.
   function automatic int id_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   // Low bit of slice idx in a flat bus of w-bit fields.
   function automatic int slice_lo(input int idx, input int w);
      return idx * w;
   endfunction

endpackage

// File: rtl/iob_cache_req_arbiter_if.sv
// IOb bundle carrying N flattened channels; N=1 for the cache side,
// N=N_REQ for the requester side.
interface iob_cache_req_arbiter_if #(
   parameter int N      = 1,
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   logic [N-1:0]          avalid;
   logic [N*ADDR_W-1:0]   addr;
   logic [N*DATA_W-1:0]   wdata;
   logic [N*DATA_W/8-1:0] wstrb;
   logic [N-1:0]          ready;
   logic [N-1:0]          rvalid;
   logic [N*DATA_W-1:0]   rdata;

   modport master (
      output avalid, addr, wdata, wstrb,
      input  ready, rvalid, rdata
   );

   modport slave (
      input  avalid, addr, wdata, wstrb,
      output ready, rvalid, rdata
   );
endinterface

// File: rtl/iob_cache_req_arbiter_rr_prio_enc.sv
// Round-robin priority encoder: rotate requests so ptr is bit 0, pick the
// lowest set bit, then map the offset back. With no request, gnt_id = ptr.
module iob_rr_prio_enc #(
   parameter int N = 2,
   parameter int W = 1
) (
   input  logic [W-1:0] ptr,
   input  logic [N-1:0] req,
   output logic [W-1:0] gnt_id,
   output logic         gnt_vld
);

   logic [N-1:0] rot;
   logic [W-1:0] off;
   logic [W:0]   gsum;

   genvar gi;
   generate
      for (gi = 0; gi < N; gi++) begin : g_rot
         logic [W:0] idx;
         always_comb begin
            idx = {1'b0, ptr} + (W+1)'(gi);
            if (idx >= (W+1)'(N)) begin
               idx = idx - (W+1)'(N);
            end
            rot[gi] = req[idx[W-1:0]];
         end
      end
   endgenerate

   always_comb begin
      off     = '0;
      gnt_vld = 1'b0;
      for (int i = N - 1; i >= 0; i--) begin
         if (rot[i]) begin
            off     = W'(i);
            gnt_vld = 1'b1;
         end
      end
      gsum = {1'b0, ptr} + {1'b0, off};
      if (gsum >= (W+1)'(N)) begin
         gsum = gsum - (W+1)'(N);
      end
      gnt_id = gsum[W-1:0];
   end

endmodule

// File: rtl/iob_cache_req_arbiter.sv
// Round-robin arbiter sharing one cache IOb front-end between N_REQ requesters,
// with at most one read outstanding and zero added latency in either direction.
module iob_cache_req_arbiter
   import iob_cache_req_arbiter_pkg::*;
#(
   parameter int  N_REQ  = 2,
   parameter int  ADDR_W = 32,
   parameter int  DATA_W = 32,
   localparam int ID_W   = id_w(N_REQ)
) (
   input  logic                    clk_i,
   input  logic                    cke_i,
   input  logic                    rst_i,
   iob_cache_req_arbiter_if.slave  s_bus,
   iob_cache_req_arbiter_if.master m_bus,
   output logic [ID_W-1:0]         grant_o,
   output logic                    rd_pend_o
);

   localparam int STRB_W = DATA_W / 8;

   arb_state_t        state_reg, state_next;
   logic [ID_W-1:0]   rr_ptr_reg, rr_ptr_next;
   logic [ID_W-1:0]   owner_reg, owner_next;

   logic [ID_W-1:0]   grant;
   logic              gnt_vld;
   logic [ADDR_W-1:0] sel_addr;
   logic [DATA_W-1:0] sel_wdata;
   logic [STRB_W-1:0] sel_wstrb;
   logic              can_issue, issue, accept, is_read, rsp_vld;
   logic [ID_W:0]     ptr_inc;

   iob_rr_prio_enc #(
      .N (N_REQ),
      .W (ID_W)
   ) u_prio_enc (
      .ptr     (rr_ptr_reg),
      .req     (s_bus.avalid),
      .gnt_id  (grant),
      .gnt_vld (gnt_vld)
   );

   always_comb begin
      sel_addr  = '0;
      sel_wdata = '0;
      sel_wstrb = '0;
      for (int k = 0; k < N_REQ; k++) begin
         if (grant == ID_W'(k)) begin
            sel_addr  = s_bus.addr[slice_lo(k, ADDR_W) +: ADDR_W];
            sel_wdata = s_bus.wdata[slice_lo(k, DATA_W) +: DATA_W];
            sel_wstrb = s_bus.wstrb[slice_lo(k, STRB_W) +: STRB_W];
         end
      end
   end

   // The returning read frees the slot in the same cycle, like the cache's own ready.
   assign can_issue = (state_reg == ST_IDLE) | m_bus.rvalid[0];
   assign issue     = gnt_vld & can_issue;
   assign accept    = issue & m_bus.ready[0];
   assign is_read   = ~|sel_wstrb;
   assign rsp_vld   = (state_reg == ST_RD_WAIT) & m_bus.rvalid[0];
   assign ptr_inc   = {1'b0, grant} + (ID_W+1)'(1);

   assign m_bus.avalid[0] = issue;
   assign m_bus.addr      = sel_addr;
   assign m_bus.wdata     = sel_wdata;
   assign m_bus.wstrb     = sel_wstrb;

   genvar gi;
   generate
      for (gi = 0; gi < N_REQ; gi++) begin : g_req
         assign s_bus.ready[gi]  = accept & (grant == ID_W'(gi));
         assign s_bus.rvalid[gi] = rsp_vld & (owner_reg == ID_W'(gi));
         assign s_bus.rdata[slice_lo(gi, DATA_W) +: DATA_W] = m_bus.rdata;
      end
   endgenerate

   assign grant_o   = grant;
   assign rd_pend_o = (state_reg == ST_RD_WAIT);

   always_comb begin
      state_next  = state_reg;
      owner_next  = owner_reg;
      rr_ptr_next = rr_ptr_reg;
      if (accept) begin
         rr_ptr_next = (ptr_inc == (ID_W+1)'(N_REQ)) ? '0 : ptr_inc[ID_W-1:0];
      end
      // A read accepted alongside a response keeps the slot busy for the new owner.
      if (accept && is_read) begin
         state_next = ST_RD_WAIT;
         owner_next = grant;
      end else if (rsp_vld) begin
         state_next = ST_IDLE;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_reg  <= ST_IDLE;
         rr_ptr_reg <= '0;
         owner_reg  <= '0;
      end else if (cke_i) begin
         state_reg  <= state_next;
         rr_ptr_reg <= rr_ptr_next;
         owner_reg  <= owner_next;
      end
   end

`ifndef SYNTHESIS
   logic [N_REQ-1:0] req_vec;
   logic             m_rvalid, m_stall;
   assign req_vec  = s_bus.avalid;
   assign m_rvalid = m_bus.rvalid[0];
   assign m_stall  = cke_i & issue & ~m_bus.ready[0];

   a_rvalid_without_pend: assert property (
      @(posedge clk_i) disable iff (rst_i) m_rvalid |-> rd_pend_o);

   a_grant_dropped: assert property (
      @(posedge clk_i) disable iff (rst_i) m_stall |=> req_vec[$past(grant)]);
`endif

endmodule

// File: tb/tb_iob_cache_req_arbiter.sv
// Scoreboard bench for iob_cache_req_arbiter with N_REQ=4: stimulus queues the
// expected accepts/responses, a negedge monitor checks them as they appear.
module tb_iob_cache_req_arbiter;

   localparam int N  = 4;
   localparam int AW = 32;
   localparam int DW = 32;

   typedef struct {
      int          id;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  wstrb;
   } acc_t;

   typedef struct {
      int          id;
      logic [31:0] data;
   } rsp_t;

   logic       clk_i = 1'b0;
   logic       cke_i;
   logic       rst_i;
   logic [1:0] grant_o;
   logic       rd_pend_o;

   int total = 0;
   int bad   = 0;

   acc_t acc_q[$];
   rsp_t rsp_q[$];

   iob_cache_req_arbiter_if #(.N(N), .ADDR_W(AW), .DATA_W(DW)) s_bus ();
   iob_cache_req_arbiter_if #(.N(1), .ADDR_W(AW), .DATA_W(DW)) m_bus ();

   iob_cache_req_arbiter #(
      .N_REQ  (N),
      .ADDR_W (AW),
      .DATA_W (DW)
   ) dut (
      .clk_i     (clk_i),
      .cke_i     (cke_i),
      .rst_i     (rst_i),
      .s_bus     (s_bus),
      .m_bus     (m_bus),
      .grant_o   (grant_o),
      .rd_pend_o (rd_pend_o)
   );

   always #5 clk_i = ~clk_i;

   function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total = total + 1;
      if (act !== exp) begin
         bad = bad + 1;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endfunction

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic neg();
      @(negedge clk_i);
   endtask

   task automatic set_req(input int k, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
      s_bus.avalid[k]         = 1'b1;
      s_bus.addr[k*32 +: 32]  = a;
      s_bus.wdata[k*32 +: 32] = d;
      s_bus.wstrb[k*4 +: 4]   = s;
   endtask

   task automatic clr_req(input int k);
      s_bus.avalid[k]         = 1'b0;
      s_bus.addr[k*32 +: 32]  = '0;
      s_bus.wdata[k*32 +: 32] = '0;
      s_bus.wstrb[k*4 +: 4]   = '0;
   endtask

   task automatic exp_acc(input int k, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
      acc_t e;
      e.id = k; e.addr = a; e.wdata = d; e.wstrb = s;
      acc_q.push_back(e);
   endtask

   task automatic exp_rsp(input int k, input logic [31:0] d);
      rsp_t e;
      e.id = k; e.data = d;
      rsp_q.push_back(e);
   endtask

   // Monitor: every accept or response the DUT presents must match the queue head.
   acc_t       mon_a;
   rsp_t       mon_r;
   logic [3:0] mon_hot;

   always @(negedge clk_i) begin
      if (s_bus.ready != '0) begin
         if (acc_q.size() == 0) begin
            chk("acc_unexpected", 64'(s_bus.ready), 64'h0);
         end else begin
            mon_a   = acc_q.pop_front();
            mon_hot = 4'b0001 << mon_a.id;
            $display("acc  id=%0d addr=%08h wdata=%08h wstrb=%b ready=%b grant=%0d",
                     mon_a.id, m_bus.addr, m_bus.wdata, m_bus.wstrb, s_bus.ready, grant_o);
            chk("acc_ready", 64'(s_bus.ready), 64'(mon_hot));
            chk("acc_grant", 64'(grant_o), 64'(mon_a.id));
            chk("acc_addr", 64'(m_bus.addr), 64'(mon_a.addr));
            chk("acc_wdata", 64'(m_bus.wdata), 64'(mon_a.wdata));
            chk("acc_wstrb", 64'(m_bus.wstrb), 64'(mon_a.wstrb));
         end
      end
      if (s_bus.rvalid != '0) begin
         if (rsp_q.size() == 0) begin
            chk("rsp_unexpected", 64'(s_bus.rvalid), 64'h0);
         end else begin
            mon_r   = rsp_q.pop_front();
            mon_hot = 4'b0001 << mon_r.id;
            $display("rsp  id=%0d rvalid=%b rdata=%08h",
                     mon_r.id, s_bus.rvalid, s_bus.rdata[mon_r.id*32 +: 32]);
            chk("rsp_rvalid", 64'(s_bus.rvalid), 64'(mon_hot));
            chk("rsp_rdata", 64'(s_bus.rdata[mon_r.id*32 +: 32]), 64'(mon_r.data));
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_i        = 1'b1;
      cke_i        = 1'b1;
      s_bus.avalid = '0;
      s_bus.addr   = '0;
      s_bus.wdata  = '0;
      s_bus.wstrb  = '0;
      m_bus.ready  = 1'b1;
      m_bus.rvalid = 1'b0;
      m_bus.rdata  = '0;

      // Reset / idle
      repeat (2) tick();
      neg();
      chk("rst_avalid", 64'(m_bus.avalid), 64'h0);
      chk("rst_ready", 64'(s_bus.ready), 64'h0);
      chk("rst_pend", 64'(rd_pend_o), 64'h0);
      chk("rst_grant", 64'(grant_o), 64'h0);
      tick();
      rst_i = 1'b0;

      // Single read from requester 1, response one cycle later
      set_req(1, 32'h40, 32'h0, 4'h0);
      exp_acc(1, 32'h40, 32'h0, 4'h0);
      neg();
      chk("rd1_avalid", 64'(m_bus.avalid), 64'h1);
      chk("rd1_pend_c0", 64'(rd_pend_o), 64'h0);
      tick();
      clr_req(1);
      m_bus.rvalid = 1'b1;
      m_bus.rdata  = 32'hDEADBEEF;
      exp_rsp(1, 32'hDEADBEEF);
      neg();
      chk("rd1_pend_c1", 64'(rd_pend_o), 64'h1);
      tick();
      m_bus.rvalid = 1'b0;
      neg();
      chk("rd1_pend_c2", 64'(rd_pend_o), 64'h0);

      // Round-robin from a fresh pointer: all four write continuously
      tick();
      rst_i = 1'b1;
      tick();
      rst_i = 1'b0;
      for (int k = 0; k < N; k++) set_req(k, 32'h100 + 32'(k*4), 32'hA0 + 32'(k), 4'hF);
      for (int i = 0; i < 6; i++) exp_acc(i % N, 32'h100 + 32'((i % N)*4), 32'hA0 + 32'(i % N), 4'hF);
      for (int i = 0; i < 6; i++) begin
         neg();
         chk("rr_avalid", 64'(m_bus.avalid), 64'h1);
         chk("rr_pend", 64'(rd_pend_o), 64'h0);
         tick();
      end
      for (int k = 0; k < N; k++) clr_req(k);

      // Read blocking: req0 reads, req1 write waits for the delayed response
      set_req(0, 32'h200, 32'h0, 4'h0);
      exp_acc(0, 32'h200, 32'h0, 4'h0);
      neg();
      tick();
      clr_req(0);
      set_req(1, 32'h300, 32'h55, 4'hF);
      repeat (3) begin
         neg();
         chk("blk_avalid_wait", 64'(m_bus.avalid), 64'h0);
         chk("blk_pend_wait", 64'(rd_pend_o), 64'h1);
         tick();
      end
      m_bus.rvalid = 1'b1;
      m_bus.rdata  = 32'h12345678;
      exp_rsp(0, 32'h12345678);
      exp_acc(1, 32'h300, 32'h55, 4'hF);
      neg();
      chk("blk_avalid_rsp", 64'(m_bus.avalid), 64'h1);
      chk("blk_rvalid", 64'(s_bus.rvalid), 64'h1);
      chk("blk_ready", 64'(s_bus.ready), 64'h2);
      tick();
      clr_req(1);
      m_bus.rvalid = 1'b0;
      neg();
      chk("blk_pend_end", 64'(rd_pend_o), 64'h0);

      // Back-to-back reads: req1's read accepted in req0's response cycle
      set_req(0, 32'h400, 32'h0, 4'h0);
      exp_acc(0, 32'h400, 32'h0, 4'h0);
      neg();
      tick();
      clr_req(0);
      set_req(1, 32'h404, 32'h0, 4'h0);
      m_bus.rvalid = 1'b1;
      m_bus.rdata  = 32'h11110000;
      exp_rsp(0, 32'h11110000);
      exp_acc(1, 32'h404, 32'h0, 4'h0);
      neg();
      chk("b2b_pend_a", 64'(rd_pend_o), 64'h1);
      chk("b2b_avalid", 64'(m_bus.avalid), 64'h1);
      tick();
      clr_req(1);
      m_bus.rdata = 32'h22220001;
      exp_rsp(1, 32'h22220001);
      neg();
      chk("b2b_pend_b", 64'(rd_pend_o), 64'h1);
      chk("b2b_owner", 64'(s_bus.rvalid), 64'h2);
      tick();
      m_bus.rvalid = 1'b0;
      neg();
      chk("b2b_pend_end", 64'(rd_pend_o), 64'h0);

      // Reset while a read is outstanding; the late response is dropped
      set_req(2, 32'h500, 32'h0, 4'h0);
      exp_acc(2, 32'h500, 32'h0, 4'h0);
      neg();
      tick();
      clr_req(2);
      neg();
      chk("rmr_pend_before", 64'(rd_pend_o), 64'h1);
      tick();
      rst_i = 1'b1;
      tick();
      m_bus.rvalid = 1'b1;
      m_bus.rdata  = 32'hBAD0BAD0;
      neg();
      chk("rmr_rvalid", 64'(s_bus.rvalid), 64'h0);
      chk("rmr_pend", 64'(rd_pend_o), 64'h0);
      chk("rmr_rr_ptr", 64'(grant_o), 64'h0);
      tick();
      m_bus.rvalid = 1'b0;
      rst_i        = 1'b0;

      // Stall: grant holds while the cache is not ready, then pointer advances
      m_bus.ready = 1'b0;
      set_req(1, 32'h600, 32'h66, 4'h3);
      set_req(3, 32'h700, 32'h77, 4'hC);
      repeat (2) begin
         neg();
         chk("stall_avalid", 64'(m_bus.avalid), 64'h1);
         chk("stall_ready", 64'(s_bus.ready), 64'h0);
         chk("stall_grant", 64'(grant_o), 64'h1);
         tick();
      end
      m_bus.ready = 1'b1;
      exp_acc(1, 32'h600, 32'h66, 4'h3);
      neg();
      tick();
      clr_req(1);
      exp_acc(3, 32'h700, 32'h77, 4'hC);
      neg();
      tick();
      clr_req(3);
      neg();
      chk("stall_idle", 64'(m_bus.avalid), 64'h0);

      chk("acc_q_left", 64'(acc_q.size()), 64'h0);
      chk("rsp_q_left", 64'(rsp_q.size()), 64'h0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
